// File: rtl/shift_fifo_pkg.sv
// Shared definitions for the shift-register FIFO family (writer and reader sides).
package shift_fifo_pkg;

    // Width of the dropped-push counter exposed on drop_cnt.
    localparam int DROP_CNT_W = 16;

    // Status bundle shared with the writer-side tests.
    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
    } fifo_status_t;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_fifo_reader_if.sv
// Push/pop bus of the shift FIFO reader. master = producer/consumer side, slave = FIFO.
interface shift_fifo_reader_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    import shift_fifo_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic                  wen;
    logic [WIDTH-1:0]      din;
    logic                  full;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [WIDTH-1:0]      rd_data;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output wen, din, rd_ready,
        input  full, rd_valid, rd_data, count, overflow, drop_cnt
    );

    modport slave (
        input  wen, din, rd_ready,
        output full, rd_valid, rd_data, count, overflow, drop_cnt
    );

endinterface

// File: rtl/shift_fifo_storage.sv
// Shift-in storage: slot 0 takes din and every slot i takes slot i-1 on shift_en.
// Slot contents carry no reset; validity is tracked by the occupancy count outside.
module shift_fifo_storage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   shift_en,
    input  logic [WIDTH-1:0]       din,
    output logic [DEPTH*WIDTH-1:0] slots
);

    logic [DEPTH*WIDTH-1:0] slots_r;

    // Shift chain advances only on an accepted push.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            slots_r <= {slots_r[(DEPTH-1)*WIDTH-1:0], din};
        end else begin
            slots_r <= slots_r;
        end
    end

    assign slots = slots_r;

endmodule

// File: rtl/shift_fifo_reader.sv
// Shift-register FIFO with occupancy tracking and a valid/ready pop port.
// Head of the queue is slot[count-1]; rd_data is a zero-latency mux of it.
// DEPTH legal range is 2..64.
// Optional feature macro: SHIFT_FIFO_READER_DROP_CNT_EN builds a saturating
// dropped-push counter on drop_cnt; otherwise drop_cnt is tied to zero.
module shift_fifo_reader
    import shift_fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_fifo_reader_if.slave bus
);

    localparam int CW = count_width(DEPTH);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic                   full_r;
    logic                   valid_r;
    logic                   overflow_r;
    logic                   pop_s;
    logic                   push_ok_s;
    logic                   drop_s;
    logic [IW-1:0]          head_idx_s;
    logic [DEPTH*WIDTH-1:0] slots_s;
    logic [WIDTH-1:0]       slot_arr_s [DEPTH];

    // Handshake decode: full/valid come from registers only, so a pop
    // frees a slot for a push in the same cycle without a comb loop.
    assign pop_s     = valid_r & bus.rd_ready;
    assign push_ok_s = bus.wen & (~full_r | pop_s);
    assign drop_s    = bus.wen & full_r & ~pop_s;

    shift_fifo_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .shift_en (push_ok_s),
        .din      (bus.din),
        .slots    (slots_s)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign slot_arr_s[g] = slots_s[g*WIDTH +: WIDTH];
    end

    // Head index: slot[count-1]; parked at slot 0 when empty (rd_data is don't-care then).
    always_comb begin
        head_idx_s = '0;
        if (count_r != {CW{1'b0}}) begin
            head_idx_s = IW'(count_r - CW'(1));
        end else begin
            head_idx_s = '0;
        end
    end

    assign bus.rd_data = slot_arr_s[head_idx_s];

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy register with full/valid flags registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            full_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Sticky overflow: set by the first dropped push, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.count    = count_r;
    assign bus.full     = full_r;
    assign bus.rd_valid = valid_r;
    assign bus.overflow = overflow_r;

`ifdef SHIFT_FIFO_READER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // Dropped-push counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= '0;
        end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
`else
    assign bus.drop_cnt = '0;
`endif

endmodule
